// File: rtl/fetch_queue.sv
// fetch_queue: ordered multi-outstanding fetch stage that routes PCs to the boot ROM or instruction memory.
// Optional FETCH_PERF_CNT_EN adds saturating stall-on-full and dropped-response counters.
module fetch_queue #(
    parameter int              XLEN       = 64,
    parameter int              IBUF_DEPTH = 4,
    parameter logic [XLEN-1:0] BROM_BASE  = 64'h0,
    parameter int              BROM_BYTES = 65536,
    parameter logic [XLEN-1:0] MEM_LO     = 64'h1_C000,
    parameter logic [XLEN-1:0] MEM_HI     = 64'h9FFF_FFFF,
    localparam int             BA_W       = $clog2(BROM_BYTES) - 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_valid_i,
    output logic            pc_ready_o,
    input  logic            flush_i,
    input  logic            instr_mem_ready_i,
    output logic            instr_mem_req_o,
    output logic [XLEN-1:0] instr_mem_addr_o,
    input  logic            instr_valid_i,
    input  logic [31:0]     instr_i,
    input  logic            exc_valid_i,
    input  logic [4:0]      exc_code_i,
    output logic            instr_ready_o,
    output logic            brom_en_o,
    output logic [BA_W-1:0] brom_addr_o,
    input  logic [31:0]     brom_data_i,
    input  logic            decode_ready_i,
    output logic            instr_valid_o,
    output logic [31:0]     fetch_instr_o,
    output logic            exc_valid_o,
    output logic [4:0]      exc_code_o,
    output logic            flush_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_full_o,
    output logic [31:0]     perf_drop_o
`endif
);

    // Entry state table
    //   E_FREE | slot unused
    //   E_PEND | memory request issued, awaiting response
    //   E_DONE | instruction or fault stored (BROM data may still be arriving this cycle)
    typedef enum logic [1:0] {E_FREE, E_PEND, E_DONE} ent_t;

    localparam int PTR_W = $clog2(IBUF_DEPTH);
    localparam int CNT_W = $clog2(IBUF_DEPTH + 1);

    ent_t        st_q    [IBUF_DEPTH];
    logic        mem_q   [IBUF_DEPTH];
    logic        exc_q   [IBUF_DEPTH];
    logic [4:0]  code_q  [IBUF_DEPTH];
    logic [31:0] instr_q [IBUF_DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] drop_cnt;
    logic             brom_pend;
    logic [PTR_W-1:0] brom_idx;

    logic             full;
    logic             accept;
    logic             misaligned;
    logic [XLEN-1:0]  brom_off;
    logic             in_brom;
    logic             in_mem;
    logic             cls_brom;
    logic             cls_mem;
    logic             cls_exc;
    logic             head_done;
    logic             head_live;
    logic             pop;
    logic             resp_drop;
    logic             resp_fill;
    logic             fill_found;
    logic [PTR_W-1:0] fill_idx;
    logic [PTR_W-1:0] scan_idx;
    logic [CNT_W-1:0] pend_mem_cnt;
    logic [CNT_W:0]   drop_sum;
    logic [CNT_W-1:0] drop_next;

    assign full       = (count == CNT_W'(IBUF_DEPTH));
    assign pc_ready_o = ~full & instr_mem_ready_i & ~flush_i;
    assign accept     = pc_valid_i & pc_ready_o;

    assign misaligned = (pc_i[1:0] != 2'b00);
    assign brom_off   = pc_i - BROM_BASE;
    assign in_brom    = (pc_i >= BROM_BASE) && (brom_off < XLEN'(BROM_BYTES));
    assign in_mem     = (pc_i >= MEM_LO) && (pc_i <= MEM_HI);

    assign cls_brom = accept & ~misaligned & in_brom;
    assign cls_mem  = accept & ~misaligned & ~in_brom & in_mem;
    assign cls_exc  = accept & ~cls_brom & ~cls_mem;

    assign brom_en_o        = cls_brom;
    assign brom_addr_o      = cls_brom ? brom_off[BA_W+1:2] : '0;
    assign instr_mem_req_o  = cls_mem;
    assign instr_mem_addr_o = cls_mem ? pc_i : '0;
    assign instr_ready_o    = 1'b1;
    assign flush_o          = flush_i;

    // BROM data is forwarded straight from the ROM in the cycle it arrives
    assign head_done     = (st_q[rd_ptr] == E_DONE);
    assign head_live     = brom_pend && (brom_idx == rd_ptr);
    assign instr_valid_o = head_done & ~flush_i & ~exc_q[rd_ptr];
    assign exc_valid_o   = head_done & ~flush_i & exc_q[rd_ptr];
    assign fetch_instr_o = instr_valid_o ? (head_live ? brom_data_i : instr_q[rd_ptr]) : 32'h0;
    assign exc_code_o    = exc_valid_o ? code_q[rd_ptr] : 5'h0;
    assign pop           = head_done & decode_ready_i & ~flush_i;

    always_comb begin
        fill_found   = 1'b0;
        fill_idx     = '0;
        scan_idx     = '0;
        pend_mem_cnt = '0;
        for (int i = 0; i < IBUF_DEPTH; i++) begin
            scan_idx = rd_ptr + PTR_W'(i);
            if (st_q[scan_idx] == E_PEND && mem_q[scan_idx]) begin
                pend_mem_cnt = pend_mem_cnt + CNT_W'(1);
                if (!fill_found) begin
                    fill_found = 1'b1;
                    fill_idx   = scan_idx;
                end
            end
        end
    end

    assign resp_drop = instr_valid_i & (drop_cnt != '0);
    assign resp_fill = instr_valid_i & (drop_cnt == '0) & fill_found;

    // Requests still in flight at a flush become responses to discard
    always_comb begin
        drop_sum = {1'b0, drop_cnt};
        if (resp_drop)
            drop_sum = drop_sum - (CNT_W+1)'(1);
        if (flush_i)
            drop_sum = drop_sum + {1'b0, pend_mem_cnt} - (CNT_W+1)'(resp_fill);
        drop_next = (drop_sum > (CNT_W+1)'(IBUF_DEPTH)) ? CNT_W'(IBUF_DEPTH) : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < IBUF_DEPTH; i++) begin
                st_q[i]    <= E_FREE;
                mem_q[i]   <= 1'b0;
                exc_q[i]   <= 1'b0;
                code_q[i]  <= 5'h0;
                instr_q[i] <= 32'h0;
            end
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            drop_cnt  <= '0;
            brom_pend <= 1'b0;
            brom_idx  <= '0;
        end else begin
            drop_cnt <= drop_next;
            if (flush_i) begin
                for (int i = 0; i < IBUF_DEPTH; i++)
                    st_q[i] <= E_FREE;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
                brom_pend <= 1'b0;
            end else begin
                if (brom_pend)
                    instr_q[brom_idx] <= brom_data_i;
                if (resp_fill) begin
                    st_q[fill_idx]    <= E_DONE;
                    exc_q[fill_idx]   <= exc_valid_i;
                    code_q[fill_idx]  <= exc_code_i;
                    instr_q[fill_idx] <= instr_i;
                end
                if (pop) begin
                    st_q[rd_ptr] <= E_FREE;
                    rd_ptr       <= rd_ptr + PTR_W'(1);
                end
                if (accept) begin
                    st_q[wr_ptr]    <= cls_mem ? E_PEND : E_DONE;
                    mem_q[wr_ptr]   <= cls_mem;
                    exc_q[wr_ptr]   <= cls_exc;
                    code_q[wr_ptr]  <= misaligned ? 5'd0 : 5'd1;
                    instr_q[wr_ptr] <= 32'h0;
                    wr_ptr          <= wr_ptr + PTR_W'(1);
                end
                brom_pend <= cls_brom;
                brom_idx  <= wr_ptr;
                count     <= count + CNT_W'(accept) - CNT_W'(pop);
            end
        end
    end

    resp_without_request: assert property (@(posedge clk) disable iff (reset)
        !(instr_valid_i && (drop_cnt == '0) && !fill_found));

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_full_o <= 32'h0;
            perf_drop_o       <= 32'h0;
        end else begin
            if (pc_valid_i && full && perf_stall_full_o != 32'hFFFF_FFFF)
                perf_stall_full_o <= perf_stall_full_o + 32'h1;
            if (resp_drop && perf_drop_o != 32'hFFFF_FFFF)
                perf_drop_o <= perf_drop_o + 32'h1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default build, perf counters absent).
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] pc_i = '0;
    logic        pc_valid_i = 1'b0;
    logic        pc_ready_o;
    logic        flush_i = 1'b0;
    logic        instr_mem_ready_i = 1'b0;
    logic        instr_mem_req_o;
    logic [63:0] instr_mem_addr_o;
    logic        instr_valid_i = 1'b0;
    logic [31:0] instr_i = '0;
    logic        exc_valid_i = 1'b0;
    logic [4:0]  exc_code_i = '0;
    logic        instr_ready_o;
    logic        brom_en_o;
    logic [13:0] brom_addr_o;
    logic [31:0] brom_data_i = '0;
    logic        decode_ready_i = 1'b1;
    logic        instr_valid_o;
    logic [31:0] fetch_instr_o;
    logic        exc_valid_o;
    logic [4:0]  exc_code_o;
    logic        flush_o;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue dut (
        .clk               (clk),
        .reset             (reset),
        .pc_i              (pc_i),
        .pc_valid_i        (pc_valid_i),
        .pc_ready_o        (pc_ready_o),
        .flush_i           (flush_i),
        .instr_mem_ready_i (instr_mem_ready_i),
        .instr_mem_req_o   (instr_mem_req_o),
        .instr_mem_addr_o  (instr_mem_addr_o),
        .instr_valid_i     (instr_valid_i),
        .instr_i           (instr_i),
        .exc_valid_i       (exc_valid_i),
        .exc_code_i        (exc_code_i),
        .instr_ready_o     (instr_ready_o),
        .brom_en_o         (brom_en_o),
        .brom_addr_o       (brom_addr_o),
        .brom_data_i       (brom_data_i),
        .decode_ready_i    (decode_ready_i),
        .instr_valid_o     (instr_valid_o),
        .fetch_instr_o     (fetch_instr_o),
        .exc_valid_o       (exc_valid_o),
        .exc_code_o        (exc_code_o),
        .flush_o           (flush_o)
    );

    always #5 clk = ~clk;

    // Boot ROM: word at address a reads as 0xB0B0_0000 | a; garbage when not enabled
    always @(posedge clk)
        brom_data_i <= brom_en_o ? (32'hB0B0_0000 | 32'(brom_addr_o)) : 32'hDEAD_0000;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = BROM, 1 = MEM, 2 = EXC; exp_val is the instruction or the fault code
    task automatic classify(input string tag, input logic [63:0] pc, input int kind,
                            input logic [13:0] baddr, input logic [31:0] exp_val);
        pc_i = pc;
        pc_valid_i = 1'b1;
        #1;
        check({tag, "_ready"}, 64'(pc_ready_o), 64'd1);
        check({tag, "_brom_en"}, 64'(brom_en_o), 64'(kind == 0));
        check({tag, "_mem_req"}, 64'(instr_mem_req_o), 64'(kind == 1));
        if (kind == 0) check({tag, "_brom_addr"}, 64'(brom_addr_o), 64'(baddr));
        if (kind == 1) check({tag, "_mem_addr"}, instr_mem_addr_o, pc);
        cyc();
        pc_valid_i = 1'b0;
        if (kind == 1) begin
            instr_valid_i = 1'b1;
            instr_i = exp_val;
            #1;
            check({tag, "_pend"}, 64'(instr_valid_o), 64'd0);
            cyc();
            instr_valid_i = 1'b0;
        end
        #1;
        if (kind == 2) begin
            check({tag, "_exc_v"}, 64'(exc_valid_o), 64'd1);
            check({tag, "_exc_code"}, 64'(exc_code_o), 64'(exp_val));
            check({tag, "_instr_v"}, 64'(instr_valid_o), 64'd0);
        end else begin
            check({tag, "_instr_v"}, 64'(instr_valid_o), 64'd1);
            check({tag, "_instr"}, 64'(fetch_instr_o), 64'(exp_val));
            check({tag, "_exc_v"}, 64'(exc_valid_o), 64'd0);
        end
        cyc();
        check({tag, "_empty"}, 64'(instr_valid_o | exc_valid_o), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc_ready", 64'(pc_ready_o), 64'd0);
        check("rst_instr_ready", 64'(instr_ready_o), 64'd1);
        check("rst_instr_v", 64'(instr_valid_o), 64'd0);
        check("rst_exc_v", 64'(exc_valid_o), 64'd0);
        check("rst_mem_req", 64'(instr_mem_req_o), 64'd0);
        check("rst_brom_en", 64'(brom_en_o), 64'd0);
        check("rst_flush_o", 64'(flush_o), 64'd0);
        reset = 1'b0;
        instr_mem_ready_i = 1'b1;
        cyc();

        // single BROM fetch, forwarded the cycle after accept
        classify("brom100", 64'h100, 0, 14'h40, 32'hB0B0_0040);

        // mixed MEM / BROM / MEM stream delivered in accept order
        pc_i = 64'h2_0000; pc_valid_i = 1'b1; #1;
        check("mix_req0", 64'(instr_mem_req_o), 64'd1);
        check("mix_addr0", instr_mem_addr_o, 64'h2_0000);
        cyc();
        pc_i = 64'h100; #1;
        check("mix_brom", 64'(brom_en_o), 64'd1);
        check("mix_head_pend", 64'(instr_valid_o), 64'd0);
        cyc();
        pc_i = 64'h2_0004; #1;
        check("mix_addr2", instr_mem_addr_o, 64'h2_0004);
        cyc();
        pc_valid_i = 1'b0; instr_valid_i = 1'b1; instr_i = 32'hAAAA_AAAA; #1;
        check("mix_wait", 64'(instr_valid_o), 64'd0);
        cyc();
        instr_valid_i = 1'b0; #1;
        check("mix_out0", 64'(fetch_instr_o), 64'hAAAA_AAAA);
        check("mix_out0_v", 64'(instr_valid_o), 64'd1);
        cyc();
        instr_valid_i = 1'b1; instr_i = 32'hBBBB_BBBB; #1;
        check("mix_out1", 64'(fetch_instr_o), 64'hB0B0_0040);
        cyc();
        instr_valid_i = 1'b0; #1;
        check("mix_out2", 64'(fetch_instr_o), 64'hBBBB_BBBB);
        cyc();
        check("mix_empty", 64'(instr_valid_o), 64'd0);

        // classification boundaries and fault codes
        classify("misalign", 64'h102, 2, 14'h0, 32'd0);
        classify("mis_brom", 64'h1, 2, 14'h0, 32'd0);
        classify("above_mem", 64'hA000_0000, 2, 14'h0, 32'd1);
        classify("brom_last", 64'hFFFC, 0, 14'h3FFF, 32'hB0B0_3FFF);
        classify("brom_end", 64'h1_0000, 2, 14'h0, 32'd1);
        classify("below_mem", 64'h1_BFFC, 2, 14'h0, 32'd1);
        classify("mem_lo", 64'h1_C000, 1, 14'h0, 32'h1357_9BDF);
        classify("mem_hi", 64'h9FFF_FFFC, 1, 14'h0, 32'h2468_ACE0);

        // fill with decode stalled, then drain
        decode_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc_i = 64'(i * 4); pc_valid_i = 1'b1; #1;
            check("fill_ready", 64'(pc_ready_o), 64'd1);
            cyc();
        end
        pc_i = 64'h10; #1;
        check("full_block", 64'(pc_ready_o), 64'd0);
        check("full_no_en", 64'(brom_en_o), 64'd0);
        check("full_head", 64'(fetch_instr_o), 64'hB0B0_0000);
        cyc(); #0;
        check("hold_head", 64'(fetch_instr_o), 64'hB0B0_0000);
        check("hold_v", 64'(instr_valid_o), 64'd1);
        cyc();
        decode_ready_i = 1'b1; #1;
        check("popfull_block", 64'(pc_ready_o), 64'd0);
        check("pop0", 64'(fetch_instr_o), 64'hB0B0_0000);
        cyc();
        check("late_accept", 64'(pc_ready_o), 64'd1);
        check("late_addr", 64'(brom_addr_o), 64'h4);
        check("pop1", 64'(fetch_instr_o), 64'hB0B0_0001);
        cyc();
        pc_valid_i = 1'b0; #1;
        check("pop2", 64'(fetch_instr_o), 64'hB0B0_0002);
        cyc();
        check("pop3", 64'(fetch_instr_o), 64'hB0B0_0003);
        cyc();
        check("pop4", 64'(fetch_instr_o), 64'hB0B0_0004);
        cyc();
        check("drain_empty", 64'(instr_valid_o), 64'd0);

        // flush with two memory requests in flight
        pc_i = 64'h2_0000; pc_valid_i = 1'b1; cyc();
        pc_i = 64'h2_0004; cyc();
        pc_valid_i = 1'b0; flush_i = 1'b1; #1;
        check("fl_flush_o", 64'(flush_o), 64'd1);
        check("fl_no_accept", 64'(pc_ready_o), 64'd0);
        cyc();
        flush_i = 1'b0; pc_i = 64'h2_0100; pc_valid_i = 1'b1; #1;
        check("fl_new_req", 64'(instr_mem_req_o), 64'd1);
        check("fl_new_addr", instr_mem_addr_o, 64'h2_0100);
        cyc();
        pc_valid_i = 1'b0; instr_valid_i = 1'b1; instr_i = 32'h1111_1111; #1;
        check("fl_drop0", 64'(instr_valid_o), 64'd0);
        cyc();
        instr_i = 32'h2222_2222; #1;
        check("fl_drop1", 64'(instr_valid_o), 64'd0);
        cyc();
        instr_i = 32'h3333_3333; #1;
        check("fl_drop2", 64'(instr_valid_o), 64'd0);
        cyc();
        instr_valid_i = 1'b0; #1;
        check("fl_keep_v", 64'(instr_valid_o), 64'd1);
        check("fl_keep", 64'(fetch_instr_o), 64'h3333_3333);
        cyc();
        check("fl_empty", 64'(instr_valid_o), 64'd0);

        // flush masks a ready head and discards the in-flight BROM read
        pc_i = 64'h100; pc_valid_i = 1'b1; cyc();
        pc_valid_i = 1'b0; flush_i = 1'b1; #1;
        check("flh_mask", 64'(instr_valid_o), 64'd0);
        cyc();
        flush_i = 1'b0; #1;
        check("flh_empty", 64'(instr_valid_o), 64'd0);
        cyc();

        // memory fault response
        pc_i = 64'h2_0200; pc_valid_i = 1'b1; cyc();
        pc_valid_i = 1'b0; instr_valid_i = 1'b1; exc_valid_i = 1'b1;
        exc_code_i = 5'd5; instr_i = 32'h0000_1234; cyc();
        instr_valid_i = 1'b0; exc_valid_i = 1'b0; #1;
        check("mexc_v", 64'(exc_valid_o), 64'd1);
        check("mexc_code", 64'(exc_code_o), 64'd5);
        check("mexc_instr_v", 64'(instr_valid_o), 64'd0);
        cyc();
        check("mexc_empty", 64'(exc_valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
